// File: rtl/doppler_freq_meter.sv
`default_nettype none
// =====================================================================
// doppler_freq_meter : I/Q rotation-rate estimator by quadrant counting
// Rev 1.0
// =====================================================================
module doppler_freq_meter #(
  parameter int SAMPLE_W = 10,
  parameter int WIN_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] real_in,
  input  logic [SAMPLE_W-1:0] imag_in,
  output logic [31:0]         freq_est,
  output logic                est_valid,
  output logic [15:0]         ambig_count,
  output logic                busy
);

  localparam int                c_ACC_W    = WIN_LOG2 + 2;
  localparam int                c_SHIFT    = 30 - WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] c_CNT_LAST = '1;
  localparam logic [15:0]       c_AMB_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                       r_est_valid;
  logic [31:0]                r_freq_est;
  logic [15:0]                r_ambig_count;
  logic signed [c_ACC_W-1:0]  r_acc;
  logic [15:0]                r_amb;
  logic [WIN_LOG2-1:0]        r_cnt;
  logic [1:0]                 r_q_prev;

  logic                       w_accept;
  logic                       w_prime_load;
  logic                       w_run_step;
  logic                       w_close;
  logic [1:0]                 w_q_new;
  logic [1:0]                 w_d;
  logic signed [c_ACC_W-1:0]  w_step;
  logic                       w_amb_inc;
  logic signed [c_ACC_W-1:0]  w_acc_nxt;
  logic [15:0]                w_amb_nxt;
  logic signed [31:0]         w_acc_ext;
  logic [31:0]                w_freq_nxt;
  logic                       w_unused_bits;

  // Only the sign bits matter; Q0..Q3 numbered counter-clockwise.
  assign w_q_new = {imag_in[SAMPLE_W-1], real_in[SAMPLE_W-1] ^ imag_in[SAMPLE_W-1]};
  assign w_unused_bits = ^{real_in[SAMPLE_W-2:0], imag_in[SAMPLE_W-2:0]};

  assign w_accept     = enable & in_valid;
  assign w_prime_load = w_accept & (r_state != S_RUN);
  assign w_run_step   = w_accept & (r_state == S_RUN);
  assign w_close      = w_run_step & (r_cnt == c_CNT_LAST);
  assign w_d          = w_q_new - r_q_prev;

  always_comb begin
    w_step    = '0;
    w_amb_inc = 1'b0;
    case (w_d)
      2'd1:    w_step = c_ACC_W'(1);
      2'd3:    w_step = '1;
      2'd2:    w_amb_inc = 1'b1;
      default: w_step = '0;
    endcase
  end

  assign w_acc_nxt  = r_acc + w_step;
  assign w_amb_nxt  = (w_amb_inc && (r_amb != c_AMB_MAX)) ? r_amb + 16'd1 : r_amb;
  assign w_acc_ext  = {{(32-c_ACC_W){w_acc_nxt[c_ACC_W-1]}}, w_acc_nxt};
  assign w_freq_nxt = w_acc_ext <<< c_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = w_accept ? S_RUN : S_PRIME;
        S_PRIME: w_state_nxt = w_accept ? S_RUN : S_PRIME;
        S_RUN:   w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_est_valid   <= 1'b0;
      r_freq_est    <= '0;
      r_ambig_count <= '0;
      r_acc         <= '0;
      r_amb         <= '0;
      r_cnt         <= '0;
      r_q_prev      <= '0;
    end else if (!enable) begin
      r_est_valid <= 1'b0;
      r_acc       <= '0;
      r_amb       <= '0;
      r_cnt       <= '0;
    end else begin
      r_est_valid <= 1'b0;
      if (w_prime_load) begin
        r_q_prev <= w_q_new;
      end
      if (w_run_step) begin
        r_q_prev <= w_q_new;
        // Window close restarts the sums in the same edge; q_prev carries over.
        if (w_close) begin
          r_est_valid   <= 1'b1;
          r_freq_est    <= w_freq_nxt;
          r_ambig_count <= w_amb_nxt;
          r_acc         <= '0;
          r_amb         <= '0;
          r_cnt         <= '0;
        end else begin
          r_acc <= w_acc_nxt;
          r_amb <= w_amb_nxt;
          r_cnt <= r_cnt + WIN_LOG2'(1);
        end
      end
    end
  end

  assign freq_est    = r_freq_est;
  assign est_valid   = r_est_valid;
  assign ambig_count = r_ambig_count;
  assign busy        = enable & (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_doppler_freq_meter.sv
`default_nettype none
// =====================================================================
// tb_doppler_freq_meter : directed and random checks of doppler_freq_meter
// Rev 1.0
// =====================================================================
module tb_doppler_freq_meter;

  localparam int SAMPLE_W = 10;
  localparam int WIN_LOG2 = 4;
  localparam int N        = 1 << WIN_LOG2;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic                in_valid;
  logic [SAMPLE_W-1:0] real_in;
  logic [SAMPLE_W-1:0] imag_in;
  logic [31:0]         freq_est;
  logic                est_valid;
  logic [15:0]         ambig_count;
  logic                busy;

  doppler_freq_meter #(.SAMPLE_W(SAMPLE_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .real_in(real_in), .imag_in(imag_in), .freq_est(freq_est),
    .est_valid(est_valid), .ambig_count(ambig_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int obs_pulses = 0;
  int cyc = 0;
  int last_pulse_cyc = -1;

  // Reference model state
  bit          m_primed;
  int          m_qprev;
  int          m_acc;
  int          m_amb;
  int          m_cnt;
  bit          m_pulse;
  logic [31:0] m_freq;
  logic [15:0] m_amb_out;

  function automatic int quad(input int i, input int q);
    if (i >= 0 && q >= 0) return 0;
    if (i < 0 && q >= 0)  return 1;
    if (i < 0)            return 2;
    return 3;
  endfunction

  function automatic int pt_i(input int k);
    return (k % 4 == 0 || k % 4 == 3) ? 100 : -100;
  endfunction

  function automatic int pt_q(input int k);
    return (k % 4 == 0) ? 0 : (k % 4 == 1) ? 50 : -50;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  task automatic model_clear_all();
    m_primed = 0; m_qprev = 0; m_acc = 0; m_amb = 0; m_cnt = 0;
    m_pulse = 0; m_freq = '0; m_amb_out = '0;
  endtask

  // Drive one clock of stimulus, advance the model, compare outputs after the edge.
  task automatic step(input bit en, input bit v, input int i, input int q);
    int qn, d;
    @(negedge clk);
    enable = en; in_valid = v;
    real_in = SAMPLE_W'(i); imag_in = SAMPLE_W'(q);
    @(posedge clk);
    #1;
    m_pulse = 0;
    if (!en) begin
      m_primed = 0; m_acc = 0; m_amb = 0; m_cnt = 0;
    end else if (v) begin
      qn = quad(i, q);
      if (!m_primed) begin
        m_primed = 1;
        m_qprev  = qn;
      end else begin
        d = (qn - m_qprev + 4) % 4;
        m_qprev = qn;
        if (d == 1) m_acc = m_acc + 1;
        else if (d == 3) m_acc = m_acc - 1;
        else if (d == 2 && m_amb < 65535) m_amb = m_amb + 1;
        m_cnt = m_cnt + 1;
        if (m_cnt == N) begin
          m_pulse   = 1;
          m_freq    = 32'(m_acc * (1 << (30 - WIN_LOG2)));
          m_amb_out = 16'(m_amb);
          m_acc = 0; m_amb = 0; m_cnt = 0;
        end
      end
    end
    cyc++;
    n_cmp++;
    if (est_valid !== m_pulse) begin
      n_fail++;
      $display("FAIL est_valid cyc=%0d: got %b expected %b", cyc, est_valid, m_pulse);
    end
    n_cmp++;
    if (busy !== en) begin
      n_fail++;
      $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, en);
    end
    n_cmp++;
    if (freq_est !== m_freq) begin
      n_fail++;
      $display("FAIL freq_est cyc=%0d: got %h expected %h", cyc, freq_est, m_freq);
    end
    n_cmp++;
    if (ambig_count !== m_amb_out) begin
      n_fail++;
      $display("FAIL ambig_count cyc=%0d: got %0d expected %0d", cyc, ambig_count, m_amb_out);
    end
    if (est_valid === 1'b1) begin
      obs_pulses++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1;
    real_in = SAMPLE_W'(100); imag_in = '0;
    model_clear_all();
    #3;
    n_cmp++;
    if ({est_valid, busy, ambig_count, freq_est} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ev=%b busy=%b amb=%0d freq=%h expected all 0",
               est_valid, busy, ambig_count, freq_est);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (est_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got ev=%b busy=%b expected 0 0", est_valid, busy);
    end
    @(negedge clk);
    enable = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    int p0;
    step(0, 0, 0, 0);
    p0 = obs_pulses; cyc = 0;
    for (int k = 0; k < 17; k++) step(1, 1, 100, 0);
    n_cmp++;
    if (obs_pulses !== p0 + 1 || last_pulse_cyc !== 17) begin
      n_fail++;
      $display("FAIL const_pulse: got %0d pulses at cyc %0d expected 1 at 17", obs_pulses - p0, last_pulse_cyc);
    end
    n_cmp++;
    if (freq_est !== 32'h0000_0000 || ambig_count !== 16'd0) begin
      n_fail++;
      $display("FAIL const_value: got freq=%h amb=%0d expected 00000000 0", freq_est, ambig_count);
    end
  endtask

  task automatic test_ccw_back_to_back();
    int p0;
    step(0, 0, 0, 0);
    p0 = obs_pulses; cyc = 0;
    for (int k = 0; k < 16; k++) step(1, 1, pt_i(k), pt_q(k));
    n_cmp++;
    if (obs_pulses !== p0) begin
      n_fail++;
      $display("FAIL ccw_early: got %0d pulses expected 0", obs_pulses - p0);
    end
    step(1, 1, pt_i(16), pt_q(16));
    n_cmp++;
    if (obs_pulses !== p0 + 1 || freq_est !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL ccw_first: got pulses=%0d freq=%h expected 1 40000000", obs_pulses - p0, freq_est);
    end
    for (int k = 17; k < 33; k++) step(1, 1, pt_i(k), pt_q(k));
    n_cmp++;
    if (obs_pulses !== p0 + 2 || last_pulse_cyc !== 33 || freq_est !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL ccw_second: got pulses=%0d at cyc %0d freq=%h expected 2 at 33 40000000",
               obs_pulses - p0, last_pulse_cyc, freq_est);
    end
  endtask

  task automatic test_cw_slow();
    step(0, 0, 0, 0);
    for (int n = 0; n < 17; n++) begin
      int k;
      k = (4 - (n / 4) % 4) % 4;
      step(1, 1, pt_i(k), pt_q(k));
    end
    n_cmp++;
    if (freq_est !== 32'hF000_0000 || ambig_count !== 16'd0) begin
      n_fail++;
      $display("FAIL cw_slow: got freq=%h amb=%0d expected f0000000 0", freq_est, ambig_count);
    end
  endtask

  task automatic test_ambig();
    step(0, 0, 0, 0);
    for (int n = 0; n < 17; n++) step(1, 1, pt_i(2 * (n % 2)), pt_q(2 * (n % 2)));
    n_cmp++;
    if (freq_est !== 32'h0 || ambig_count !== 16'd16) begin
      n_fail++;
      $display("FAIL ambig: got freq=%h amb=%0d expected 00000000 16", freq_est, ambig_count);
    end
  endtask

  task automatic test_gapped_valid();
    int p0, k;
    step(0, 0, 0, 0);
    p0 = obs_pulses; cyc = 0; k = 0;
    for (int c = 0; c < 33; c++) begin
      if (c % 2 == 0) begin
        step(1, 1, pt_i(k), pt_q(k));
        k++;
      end else begin
        step(1, 0, rnd_sample(), rnd_sample());
      end
    end
    n_cmp++;
    if (obs_pulses !== p0 + 1 || last_pulse_cyc !== 33 || freq_est !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL gapped: got pulses=%0d at cyc %0d freq=%h expected 1 at 33 40000000",
               obs_pulses - p0, last_pulse_cyc, freq_est);
    end
  endtask

  task automatic test_enable_drop();
    int p0;
    step(0, 0, 0, 0);
    p0 = obs_pulses;
    for (int k = 0; k < 8; k++) step(1, 1, pt_i(k), pt_q(k));
    step(0, 1, 100, 0);
    step(0, 0, 100, 0);
    cyc = 0;
    // Fast clockwise rotation: one quadrant back per sample.
    for (int n = 0; n < 16; n++) step(1, 1, pt_i(4 - n % 4), pt_q(4 - n % 4));
    n_cmp++;
    if (obs_pulses !== p0) begin
      n_fail++;
      $display("FAIL en_drop_partial: got %0d pulses expected 0", obs_pulses - p0);
    end
    step(1, 1, pt_i(0), pt_q(0));
    n_cmp++;
    if (obs_pulses !== p0 + 1 || last_pulse_cyc !== 17 || freq_est !== 32'hC000_0000) begin
      n_fail++;
      $display("FAIL en_drop_window: got pulses=%0d at cyc %0d freq=%h expected 1 at 17 c0000000",
               obs_pulses - p0, last_pulse_cyc, freq_est);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = obs_pulses;
    for (int k = 0; k < 8; k++) step(1, 1, pt_i(k), pt_q(k));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({est_valid, busy, ambig_count, freq_est} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_async: got ev=%b busy=%b amb=%0d freq=%h expected all 0",
               est_valid, busy, ambig_count, freq_est);
    end
    model_clear_all();
    @(negedge clk);
    enable = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 16; k++) step(1, 1, pt_i(k), pt_q(k));
    n_cmp++;
    if (obs_pulses !== p0) begin
      n_fail++;
      $display("FAIL reset_partial: got %0d pulses expected 0", obs_pulses - p0);
    end
    step(1, 1, pt_i(16), pt_q(16));
    n_cmp++;
    if (obs_pulses !== p0 + 1 || freq_est !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL reset_window: got pulses=%0d freq=%h expected 1 40000000", obs_pulses - p0, freq_est);
    end
  endtask

  task automatic test_random();
    int p0;
    p0 = obs_pulses;
    step(0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, rnd_sample(), rnd_sample());
    end
    n_cmp++;
    if (obs_pulses - p0 < 3) begin
      n_fail++;
      $display("FAIL random_windows: got %0d completed windows expected at least 3", obs_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ccw_back_to_back();
    test_cw_slow();
    test_ambig();
    test_gapped_valid();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
